rs_encode_multi_stream_in_ctrl: RTL

// Input-side controller for the multi-unit Reed-Solomon stream encoder. Accepts an encode request,

---
 rtl/rs_encode_pkg.sv | 8 +
 rtl/rs_rr_unit_ptr.sv | 19 +
 rtl/rs_encode_multi_stream_in_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rs_encode_pkg.sv
// rs_encode_pkg: shared state enums and width helper for the RS encoder input controller.
package rs_encode_pkg;
  typedef enum logic [1:0] {ST_READY, ST_ENCODE, ST_PAD, ST_DRAIN} state_e;
  typedef enum logic {META_DONE, META_PENDING} meta_e;
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rs_rr_unit_ptr.sv
// rs_rr_unit_ptr: round-robin modulo-N pointer that advances on incr_i.
module rs_rr_unit_ptr
  import rs_encode_pkg::*;
#(
  parameter int N = 4,
  parameter int W = clog2_min1(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         incr_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  assign ptr_d = !incr_i ? ptr_q : (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/rs_encode_multi_stream_in_ctrl.sv
// rs_encode_multi_stream_in_ctrl: accepts encode requests and spreads payload blocks round-robin over RS units.
module rs_encode_multi_stream_in_ctrl
  import rs_encode_pkg::*;
#(
  parameter int NUM_RS_UNITS = 4,
  parameter int DATA_LINES   = 8,
  parameter int TOTAL_LINES  = 10,
  parameter int BLK_CNT_W    = 16,
  localparam int UNIT_W      = clog2_min1(NUM_RS_UNITS),
  localparam int LINE_W      = clog2_min1(TOTAL_LINES)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_val_i,
  output logic                    req_rdy_o,
  input  logic [BLK_CNT_W-1:0]    req_num_blocks_i,
  input  logic                    req_shorten_i,
  input  logic                    data_val_i,
  output logic                    data_rdy_o,
  output logic                    enc_val_o,
  input  logic [NUM_RS_UNITS-1:0] enc_rdy_i,
  output logic [UNIT_W-1:0]       enc_unit_sel_o,
  output logic                    enc_pad_o,
  output logic                    enc_last_o,
  output logic                    meta_val_o,
  input  logic                    meta_rdy_i,
  output logic [BLK_CNT_W-1:0]    meta_num_blocks_o,
  output logic [UNIT_W-1:0]       meta_start_unit_o,
  output logic                    busy_o
);
  localparam logic [LINE_W-1:0] DL_LAST = LINE_W'(DATA_LINES - 1);
  localparam logic [LINE_W-1:0] TL_LAST = LINE_W'(TOTAL_LINES - 1);
  localparam bit NO_PAD = (DATA_LINES == TOTAL_LINES);

  state_e                state_q, state_d;
  meta_e                 meta_q, meta_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [BLK_CNT_W-1:0]  blk_q, blk_d, nb_q, nb_d;
  logic                  sh_q, sh_d;
  logic [UNIT_W-1:0]     start_q, start_d, unit_ptr;
  logic                  sel_rdy, accept, blk_end;

  rs_rr_unit_ptr #(.N(NUM_RS_UNITS), .W(UNIT_W)) u_ptr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .incr_i (blk_end),
    .ptr_o  (unit_ptr)
  );

  // Only the currently selected unit's ready matters; other units may stall freely.
  assign sel_rdy = enc_rdy_i[unit_ptr];

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    blk_d      = blk_q;
    nb_d       = nb_q;
    sh_d       = sh_q;
    start_d    = start_q;
    req_rdy_o  = 1'b0;
    data_rdy_o = 1'b0;
    enc_val_o  = 1'b0;
    enc_pad_o  = 1'b0;
    enc_last_o = 1'b0;
    accept     = 1'b0;
    blk_end    = 1'b0;
    case (state_q)
      ST_READY: begin
        req_rdy_o = 1'b1;
        line_d    = '0;
        blk_d     = '0;
        if (req_val_i) begin
          accept  = 1'b1;
          nb_d    = req_num_blocks_i;
          sh_d    = req_shorten_i;
          start_d = unit_ptr;
          state_d = (req_num_blocks_i == '0) ? ST_DRAIN : ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        enc_val_o  = data_val_i;
        data_rdy_o = sel_rdy;
        enc_last_o = data_val_i && line_q == DL_LAST && (sh_q || NO_PAD);
        if (data_val_i && sel_rdy) begin
          line_d = line_q + LINE_W'(1);
          if (line_q == DL_LAST) begin
            blk_end = sh_q || NO_PAD;
            if (!blk_end) state_d = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        enc_val_o  = 1'b1;
        enc_pad_o  = 1'b1;
        enc_last_o = line_q == TL_LAST;
        if (sel_rdy) begin
          line_d  = line_q + LINE_W'(1);
          blk_end = enc_last_o;
        end
      end
      ST_DRAIN: if (meta_q == META_DONE || meta_rdy_i) state_d = ST_READY;
      default: state_d = state_e'('x);
    endcase
    if (blk_end) begin
      line_d  = '0;
      blk_d   = blk_q + BLK_CNT_W'(1);
      state_d = (blk_q == nb_q - BLK_CNT_W'(1)) ? ST_DRAIN : ST_ENCODE;
    end
  end

  // Metadata handshake runs alongside payload flow and never holds it back.
  always_comb begin
    meta_val_o = meta_q == META_PENDING;
    meta_d     = accept ? META_PENDING : (meta_val_o && meta_rdy_i) ? META_DONE : meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ST_READY;
      meta_q  <= META_DONE;
    end else begin
      state_q <= state_d;
      meta_q  <= meta_d;
    end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      line_q  <= '0;
      blk_q   <= '0;
      nb_q    <= '0;
      sh_q    <= 1'b0;
      start_q <= '0;
    end else begin
      line_q  <= line_d;
      blk_q   <= blk_d;
      nb_q    <= nb_d;
      sh_q    <= sh_d;
      start_q <= start_d;
    end

  assign busy_o            = state_q != ST_READY;
  assign enc_unit_sel_o    = unit_ptr;
  assign meta_num_blocks_o = nb_q;
  assign meta_start_unit_o = start_q;
endmodule
